pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: boot-load sequencing, decode-stall hold and redirect flush.
// Define PIPE_CTRL_PERF_EN to add saturating STALL/FLUSH cycle counters.
module pipe_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BYTES   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_done_i,
  output logic                  load_ready_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_BYTES-1:0] wen_o,
  output logic                  pc_incr_en_o,
  input  logic                  stall_req_i,
  input  logic                  redirect_i,
  output logic                  flush_o,
  output logic [1:0]            state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_LEN = 4'(FLUSH_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_BYTES-1:0] wen_q, wen_d;
  logic                  hs;
  logic [3:0]            cnt_eff;

  assign load_ready_o = (state_q == LOAD);
  assign hs           = load_valid_i & load_ready_o;
  assign wdata_o      = wdata_q;
  assign wen_o        = wen_q;
  assign flush_o      = (state_q == FLUSH);
  assign state_o      = state_q;

  always_comb begin
    pc_incr_en_o = 1'b0;
    case (state_q)
      RUN:     pc_incr_en_o = ~stall_req_i & (wen_q == '0);
      FLUSH:   pc_incr_en_o = 1'b1;
      default: pc_incr_en_o = 1'b0;
    endcase
  end

  // cnt_q holds the flush cycles still owed including the current one; a
  // redirect inside FLUSH makes the current cycle the first of a fresh window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = hs ? load_data_i : wdata_q;
    wen_d   = hs ? '1 : '0;
    cnt_eff = redirect_i ? FLUSH_LEN : cnt_q;
    case (state_q)
      LOAD: begin
        if (load_done_i) state_d = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LEN;
        end else if (stall_req_i) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (redirect_i) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LEN;
        end else if (!stall_req_i) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (cnt_eff <= 4'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_eff - 4'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wdata_q <= '0;
      wen_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q == FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
